// File: rtl/prog_loader.sv
// Byte-stream program loader: parses host frames into instruction/data memory
// writes and parks or releases the core. Optional macro: LOADER_CHECKSUM_EN.
module prog_loader #(
    parameter int D  = 10,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    in_byte,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          im_wr_en,
    output logic [D-1:0]  im_addr,
    output logic [8:0]    im_wr_data,
    output logic          dm_wr_en,
    output logic [AW-1:0] dm_addr,
    output logic [7:0]    dm_wr_data,
    output logic          core_reset,
    input  logic          core_done,
    output logic          busy,
    output logic          err,
    output logic          done_seen
);

    localparam logic [7:0] HDR_INSTR = 8'h01;
    localparam logic [7:0] HDR_DATA  = 8'h02;
    localparam logic [7:0] HDR_RUN   = 8'h03;
    localparam logic [7:0] CMD_STOP  = 8'h04;

    typedef enum logic [2:0] {
        IDLE,
        ADDR_LO,
        ADDR_HI,
        CNT_LO,
        CNT_HI,
        PAYLOAD,
`ifdef LOADER_CHECKSUM_EN
        CHK,
`endif
        RUN
    } state_t;

    state_t         state_q, state_d;
    state_t         frame_end_state;
    logic [15:0]    addr_q, addr_d;
    logic [15:0]    cnt_q, cnt_d;
    logic           is_instr_q, is_instr_d;
    logic           half_q, half_d;
    logic [7:0]     lo_byte_q, lo_byte_d;
    logic           err_q, err_d;
    logic           done_seen_q, done_seen_d;
    logic           im_wr_en_q, im_wr_en_d;
    logic [D-1:0]   im_addr_q, im_addr_d;
    logic [8:0]     im_wr_data_q, im_wr_data_d;
    logic           dm_wr_en_q, dm_wr_en_d;
    logic [AW-1:0]  dm_addr_q, dm_addr_d;
    logic [7:0]     dm_wr_data_q, dm_wr_data_d;
    logic           accept;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]     sum_q, sum_d;

    assign frame_end_state = CHK;
`else
    assign frame_end_state = IDLE;
`endif

    // The cycle carrying a write strobe is the one-cycle bubble of each item.
    assign in_ready   = !reset && !im_wr_en_q && !dm_wr_en_q;
    assign accept     = in_valid && in_ready;
    assign core_reset = (state_q != RUN);
    assign busy       = (state_q != IDLE) && (state_q != RUN);
    assign err        = err_q;
    assign done_seen  = done_seen_q;
    assign im_wr_en   = im_wr_en_q;
    assign im_addr    = im_addr_q;
    assign im_wr_data = im_wr_data_q;
    assign dm_wr_en   = dm_wr_en_q;
    assign dm_addr    = dm_addr_q;
    assign dm_wr_data = dm_wr_data_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            cnt_q        <= '0;
            is_instr_q   <= 1'b0;
            half_q       <= 1'b0;
            lo_byte_q    <= '0;
            err_q        <= 1'b0;
            done_seen_q  <= 1'b0;
            im_wr_en_q   <= 1'b0;
            im_addr_q    <= '0;
            im_wr_data_q <= '0;
            dm_wr_en_q   <= 1'b0;
            dm_addr_q    <= '0;
            dm_wr_data_q <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            is_instr_q   <= is_instr_d;
            half_q       <= half_d;
            lo_byte_q    <= lo_byte_d;
            err_q        <= err_d;
            done_seen_q  <= done_seen_d;
            im_wr_en_q   <= im_wr_en_d;
            im_addr_q    <= im_addr_d;
            im_wr_data_q <= im_wr_data_d;
            dm_wr_en_q   <= dm_wr_en_d;
            dm_addr_q    <= dm_addr_d;
            dm_wr_data_q <= dm_wr_data_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q        <= sum_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        is_instr_d   = is_instr_q;
        half_d       = half_q;
        lo_byte_d    = lo_byte_q;
        err_d        = err_q;
        done_seen_d  = done_seen_q;
        im_wr_en_d   = 1'b0;
        im_addr_d    = im_addr_q;
        im_wr_data_d = im_wr_data_q;
        dm_wr_en_d   = 1'b0;
        dm_addr_d    = dm_addr_q;
        dm_wr_data_d = dm_wr_data_q;
`ifdef LOADER_CHECKSUM_EN
        sum_d        = sum_q;
        if (accept && (state_q != IDLE) && (state_q != RUN) && (state_q != CHK)) begin
            sum_d = sum_q + in_byte;
        end
`endif

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    case (in_byte)
                        HDR_INSTR, HDR_DATA: begin
                            is_instr_d = (in_byte == HDR_INSTR);
                            state_d    = ADDR_LO;
`ifdef LOADER_CHECKSUM_EN
                            sum_d      = in_byte;
`endif
                        end
                        HDR_RUN: begin
                            done_seen_d = 1'b0;
                            state_d     = RUN;
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            end
            ADDR_LO: begin
                if (accept) begin
                    addr_d[7:0] = in_byte;
                    state_d     = ADDR_HI;
                end
            end
            ADDR_HI: begin
                if (accept) begin
                    addr_d[15:8] = in_byte;
                    state_d      = CNT_LO;
                end
            end
            CNT_LO: begin
                if (accept) begin
                    cnt_d[7:0] = in_byte;
                    state_d    = CNT_HI;
                end
            end
            CNT_HI: begin
                if (accept) begin
                    cnt_d[15:8] = in_byte;
                    half_d      = 1'b0;
                    state_d     = ({in_byte, cnt_q[7:0]} == 16'd0) ? frame_end_state : PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (accept) begin
                    if (is_instr_q && !half_q) begin
                        lo_byte_d = in_byte;
                        half_d    = 1'b1;
                    end else begin
                        // Final byte of an item: register the write, advance address and count.
                        if (is_instr_q) begin
                            im_wr_en_d   = 1'b1;
                            im_addr_d    = addr_q[D-1:0];
                            im_wr_data_d = {in_byte[0], lo_byte_q};
                            if (in_byte[7:1] != 7'd0) begin
                                err_d = 1'b1;
                            end
                        end else begin
                            dm_wr_en_d   = 1'b1;
                            dm_addr_d    = addr_q[AW-1:0];
                            dm_wr_data_d = in_byte;
                        end
                        half_d = 1'b0;
                        addr_d = addr_q + 16'd1;
                        cnt_d  = cnt_q - 16'd1;
                        if (cnt_q == 16'd1) begin
                            state_d = frame_end_state;
                        end
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CHK: begin
                if (accept) begin
                    if (in_byte != sum_q) begin
                        err_d = 1'b1;
                    end
                    state_d = IDLE;
                end
            end
`endif
            RUN: begin
                if (core_done) begin
                    done_seen_d = 1'b1;
                end
                if (accept && (in_byte == CMD_STOP)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
